// File: rtl/memory_stage.sv
// Memory stage: single-outstanding LD/ST issue with bounded wait, sticky timeout flag, and writeback.
// Registered outputs (1-cycle ALU latency); stall_upstream is combinational and holds earlier stages during an access.
module memory_stage #(
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [2:0] DEST_NULL   = 3'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ex_op,
  input  logic [2:0]  ex_dest,
  input  logic [15:0] ex_value,
  input  logic [15:0] ex_store_data,
  input  logic        ex_write_enable,
  output logic        stall_upstream,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [2:0]  wb_dest,
  output logic [15:0] wb_value,
  output logic        wb_write_enable,
  output logic        mem_error
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_ST  = 4'h4;
  localparam logic [3:0] OP_SUB = 4'hf;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wait_count, wait_count_nx;
  logic [2:0]    dest_lat, dest_lat_nx;
  logic          mem_req_nx, mem_we_nx, wb_we_nx, mem_error_nx;
  logic [15:0]   mem_addr_nx, mem_wdata_nx, wb_value_nx;
  logic [2:0]    wb_dest_nx;
  logic          is_mem_op, timeout_hit;

  assign is_mem_op   = (ex_op == OP_LD) || (ex_op == OP_ST);
  assign timeout_hit = (state == ST_WAIT) && !mem_ack && (wait_count == LAST_WAIT);

  // Reset forces the IDLE view so upstream sees a stall for a presented LD/ST even while reset is held.
  assign stall_upstream = (reset || state == ST_IDLE) ? is_mem_op
                                                      : (!mem_ack && !timeout_hit);

  always_comb begin
    state_nx      = state;
    wait_count_nx = wait_count;
    dest_lat_nx   = dest_lat;
    mem_req_nx    = mem_req;
    mem_we_nx     = mem_we;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;
    wb_dest_nx    = wb_dest;
    wb_value_nx   = wb_value;
    wb_we_nx      = 1'b0;
    mem_error_nx  = mem_error;
    case (state)
      ST_IDLE: begin
        if (ex_op == OP_ADD || ex_op == OP_SUB) begin
          wb_dest_nx  = ex_dest;
          wb_value_nx = ex_value;
          wb_we_nx    = ex_write_enable && (ex_dest != DEST_NULL);
        end else if (is_mem_op) begin
          state_nx      = ST_WAIT;
          dest_lat_nx   = ex_dest;
          mem_req_nx    = 1'b1;
          mem_addr_nx   = ex_value;
          mem_we_nx     = (ex_op == OP_ST);
          mem_wdata_nx  = ex_store_data;
          wait_count_nx = '0;
        end
      end
      ST_WAIT: begin
        // Ack wins over a coincident timeout.
        if (mem_ack) begin
          state_nx   = ST_IDLE;
          mem_req_nx = 1'b0;
          if (!mem_we) begin
            wb_dest_nx  = dest_lat;
            wb_value_nx = mem_rdata;
            wb_we_nx    = (dest_lat != DEST_NULL);
          end
        end else if (timeout_hit) begin
          state_nx     = ST_IDLE;
          mem_req_nx   = 1'b0;
          mem_error_nx = 1'b1;
        end else begin
          wait_count_nx = wait_count + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      wait_count      <= '0;
      dest_lat        <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      wb_dest         <= '0;
      wb_value        <= '0;
      wb_write_enable <= 1'b0;
      mem_error       <= 1'b0;
    end else begin
      state           <= state_nx;
      wait_count      <= wait_count_nx;
      dest_lat        <= dest_lat_nx;
      mem_req         <= mem_req_nx;
      mem_we          <= mem_we_nx;
      mem_addr        <= mem_addr_nx;
      mem_wdata       <= mem_wdata_nx;
      wb_dest         <= wb_dest_nx;
      wb_value        <= wb_value_nx;
      wb_write_enable <= wb_we_nx;
      mem_error       <= mem_error_nx;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios with literal expectations, then random traffic against an access-level model.
module tb_memory_stage;
  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ex_op;
  logic [2:0]  ex_dest;
  logic [15:0] ex_value, ex_store_data, mem_rdata;
  logic        ex_write_enable, mem_ack;
  logic        stall_upstream, mem_req, mem_we, wb_write_enable, mem_error;
  logic [15:0] mem_addr, mem_wdata, wb_value;
  logic [2:0]  wb_dest;

  memory_stage #(.MEM_TIMEOUT(T), .DEST_NULL(3'd7)) dut (
    .clk(clk), .reset(reset), .ex_op(ex_op), .ex_dest(ex_dest), .ex_value(ex_value),
    .ex_store_data(ex_store_data), .ex_write_enable(ex_write_enable),
    .stall_upstream(stall_upstream), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_dest(wb_dest), .wb_value(wb_value), .wb_write_enable(wb_write_enable),
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: one outstanding access record plus the expected writeback and error flag.
  bit          model_valid = 0;
  bit          acc_busy = 0;
  int          acc_age  = 0;
  bit          acc_store = 0;
  logic [15:0] acc_addr = '0, acc_wdata = '0;
  logic [2:0]  acc_dest = '0;
  bit          e_we = 0, e_err = 0;
  logic [2:0]  e_dest = '0;
  logic [15:0] e_value = '0;

  bit last_stall, last_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_stall(input logic [3:0] op, input logic ack, input logic rst);
    bit ls;
    ls = (op == 4'h3) || (op == 4'h4);
    if (rst || !acc_busy) return ls;
    return !ack && (acc_age != T - 1);
  endfunction

  task automatic model_advance(input logic [3:0] op, input logic [2:0] d, input logic [15:0] v,
                               input logic [15:0] sd, input logic we, input logic ack,
                               input logic [15:0] rd, input logic rst);
    if (rst) begin
      acc_busy = 0; acc_age = 0; acc_store = 0; acc_addr = '0; acc_wdata = '0; acc_dest = '0;
      e_we = 0; e_err = 0; e_dest = '0; e_value = '0;
      model_valid = 1;
      return;
    end
    e_we = 0;
    if (!acc_busy) begin
      if (op == 4'h0 || op == 4'hf) begin
        e_dest = d; e_value = v; e_we = we && (d != 3'd7);
      end else if (op == 4'h3 || op == 4'h4) begin
        acc_busy = 1; acc_age = 0; acc_store = (op == 4'h4);
        acc_addr = v; acc_wdata = sd; acc_dest = d;
      end
    end else if (ack) begin
      acc_busy = 0;
      if (!acc_store) begin
        e_dest = acc_dest; e_value = rd; e_we = (acc_dest != 3'd7);
      end
    end else if (acc_age == T - 1) begin
      acc_busy = 0; e_err = 1;
    end else begin
      acc_age++;
    end
  endtask

  // One clock cycle: drive at negedge, compare everything against the model, advance model, pass posedge.
  task automatic step(input logic [3:0] op, input logic [2:0] d, input logic [15:0] v,
                      input logic [15:0] sd, input logic we, input logic ack,
                      input logic [15:0] rd, input logic rst);
    @(negedge clk);
    ex_op = op; ex_dest = d; ex_value = v; ex_store_data = sd; ex_write_enable = we;
    mem_ack = ack; mem_rdata = rd; reset = rst;
    #1;
    chk("stall_upstream", 32'(stall_upstream), 32'(exp_stall(op, ack, rst)));
    last_stall = stall_upstream;
    last_req   = mem_req;
    if (model_valid) begin
      chk("mem_req", 32'(mem_req), 32'(acc_busy));
      chk("mem_error", 32'(mem_error), 32'(e_err));
      chk("wb_write_enable", 32'(wb_write_enable), 32'(e_we));
      if (e_we) begin
        chk("wb_dest", 32'(wb_dest), 32'(e_dest));
        chk("wb_value", 32'(wb_value), 32'(e_value));
      end
      if (acc_busy) begin
        chk("mem_addr", 32'(mem_addr), 32'(acc_addr));
        chk("mem_we", 32'(mem_we), 32'(acc_store));
        chk("mem_wdata", 32'(mem_wdata), 32'(acc_wdata));
      end
    end
    model_advance(op, d, v, sd, we, ack, rd, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic ack);
    step(4'h2, 3'd0, 16'h0, 16'h0, 1'b0, ack, 16'h0, 1'b0);
  endtask

  initial begin
    int nreq, nstall;
    int ack_pct;
    logic [3:0] ops [9];
    ops = '{4'h0, 4'hf, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'h3};

    // Reset state
    step(4'h2, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    step(4'h2, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_wb_we", 32'(wb_write_enable), 32'd0);
    chk("rst_wb_dest", 32'(wb_dest), 32'd0);
    chk("rst_wb_value", 32'(wb_value), 32'd0);
    chk("rst_mem_error", 32'(mem_error), 32'd0);

    // ADD dest 3
    step(4'h0, 3'd3, 16'h0012, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("add_stall", 32'(last_stall), 32'd0);
    chk("add_we", 32'(wb_write_enable), 32'd1);
    chk("add_dest", 32'(wb_dest), 32'd3);
    chk("add_value", 32'(wb_value), 32'h0012);

    // ADD to the null destination
    step(4'h0, 3'd7, 16'h0099, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("null_dest_we", 32'(wb_write_enable), 32'd0);

    // LD acked on 3rd wait cycle
    nreq = 0; nstall = 0;
    step(4'h3, 3'd2, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    nreq += int'(last_req); nstall += int'(last_stall);
    for (int i = 0; i < 3; i++) begin
      step(4'h3, 3'd2, 16'h0040, 16'h0, 1'b0, (i == 2), 16'hBEEF, 1'b0);
      nreq += int'(last_req); nstall += int'(last_stall);
    end
    chk("ld_req_cycles", 32'(nreq), 32'd3);
    chk("ld_stall_cycles", 32'(nstall), 32'd3);
    chk("ld_wb_we", 32'(wb_write_enable), 32'd1);
    chk("ld_wb_dest", 32'(wb_dest), 32'd2);
    chk("ld_wb_value", 32'(wb_value), 32'hBEEF);

    // ST acked on 1st wait cycle
    step(4'h4, 3'd1, 16'h0010, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_wdata", 32'(mem_wdata), 32'h1234);
    chk("st_mem_addr", 32'(mem_addr), 32'h0010);
    nop(1'b1);
    chk("st_wb_we", 32'(wb_write_enable), 32'd0);
    chk("st_req_drop", 32'(mem_req), 32'd0);

    // Ack in IDLE is ignored
    nop(1'b1);
    chk("idle_ack_req", 32'(mem_req), 32'd0);
    chk("idle_ack_we", 32'(wb_write_enable), 32'd0);

    // LD timeout
    nreq = 0;
    step(4'h3, 3'd4, 16'h0055, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < T; i++) begin
      nop(1'b0);
      nreq += int'(last_req);
    end
    chk("to_req_cycles", 32'(nreq), 32'(T));
    chk("to_req_low", 32'(mem_req), 32'd0);
    chk("to_error", 32'(mem_error), 32'd1);
    chk("to_no_write", 32'(wb_write_enable), 32'd0);
    for (int i = 0; i < 4; i++) nop(1'b0);
    chk("to_error_sticky", 32'(mem_error), 32'd1);

    // Reset coincident with ack mid-WAIT
    step(4'h3, 3'd5, 16'h0077, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    nop(1'b0);
    step(4'h2, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1, 16'hAAAA, 1'b1);
    chk("rst_ack_req", 32'(mem_req), 32'd0);
    chk("rst_ack_we", 32'(wb_write_enable), 32'd0);
    chk("rst_ack_err", 32'(mem_error), 32'd0);

    // Ack on the would-be timeout cycle
    step(4'h3, 3'd6, 16'h0123, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < T; i++)
      step(4'h2, 3'd0, 16'h0, 16'h0, 1'b0, (i == T - 1), 16'h5A5A, 1'b0);
    chk("edge_ack_we", 32'(wb_write_enable), 32'd1);
    chk("edge_ack_value", 32'(wb_value), 32'h5A5A);
    chk("edge_ack_err", 32'(mem_error), 32'd0);

    // Random traffic
    ack_pct = 30;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) begin
        case ($urandom_range(0, 3))
          0: ack_pct = 2;
          1: ack_pct = 15;
          2: ack_pct = 50;
          default: ack_pct = 90;
        endcase
      end
      step(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 16'($urandom),
           16'($urandom), 1'($urandom), ($urandom_range(0, 99) < ack_pct),
           16'($urandom), ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
